// File: rtl/t_ms_pkg.sv
// Shared constants for the master-slave T counter: direction encoding and default width.
// Optional feature macro: T_MS_COUNTER_SAT_EN (saturate instead of wrap).
package t_ms_pkg;

   localparam logic DIR_DOWN      = 1'b0;
   localparam logic DIR_UP        = 1'b1;
   localparam int   DEFAULT_WIDTH = 4;

endpackage

// File: rtl/t_ms_stage.sv
// One bit of the counter: a master-slave T element with parallel-load path.
// Ports: clk, rst (async, active-high), t (toggle), ld/ldv (load enable/value),
// qm (master latch, transparent while clk=1), qs (slave, follows qm while clk=0).
// Optional feature macro: T_MS_COUNTER_SAT_EN (handled in the top level).
module t_ms_stage (
   input  logic clk,
   input  logic rst,
   input  logic t,
   input  logic ld,
   input  logic ldv,
   output logic qm,
   output logic qs
);

   logic qm_q;
   logic qm_d;
   logic qs_q;

   // Next master value depends only on the slave, never on the master itself.
   assign qm_d = ld ? ldv : (qs_q ^ t);

   // Master latch: transparent while clk=1, holds while clk=0.
   always_latch begin
      if (rst) begin
         qm_q <= 1'b0;
      end else if (clk) begin
         qm_q <= qm_d;
      end
   end

   // Slave: qm is frozen while clk=0, so following it during the low phase
   // is the same as capturing it at the falling edge.
   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         qs_q <= 1'b0;
      end else begin
         qs_q <= qm_q;
      end
   end

   assign qm = qm_q;
   assign qs = qs_q;

endmodule

// File: rtl/t_ms_counter.sv
// Up/down counter built from WIDTH master-slave T elements; the visible count
// is qs, updated at the falling edge of clk. Ports: clk, rst (async, active-high),
// en, up, load, d[WIDTH] in; qm[WIDTH], qs[WIDTH], tc out.
// Optional feature macro: T_MS_COUNTER_SAT_EN (hold at the end value instead of wrapping).
module t_ms_counter
   import t_ms_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] qm,
   output logic [WIDTH-1:0] qs,
   output logic             tc
);

   logic [WIDTH-1:0] tog;
   logic             run;

   assign tc = (up == DIR_UP) ? (&qs) : ~(|qs);

   // Carry/borrow chain: bit i toggles when all lower bits are at the
   // direction's end value (all ones counting up, all zeros counting down).
   always_comb begin
      tog = '0;
      run = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         tog[i] = en & run;
         run    = run & ((up == DIR_UP) ? qs[i] : ~qs[i]);
      end
`ifdef T_MS_COUNTER_SAT_EN
      if (tc && en && !load) begin
         tog = '0;
      end
`endif
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      t_ms_stage u_stage (
         .clk (clk),
         .rst (rst),
         .t   (tog[i]),
         .ld  (load),
         .ldv (d[i]),
         .qm  (qm[i]),
         .qs  (qs[i])
      );
   end

endmodule

// File: tb/tb_t_ms_counter.sv
// Scoreboard bench for t_ms_counter: directed scenarios plus random traffic
// against an arithmetic reference model. Honours T_MS_COUNTER_SAT_EN.
module tb_t_ms_counter;

   localparam int W = 4;
   localparam int M = 1 << W;
`ifdef T_MS_COUNTER_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic         clk;
   logic         rst;
   logic         en;
   logic         up;
   logic         load;
   logic [W-1:0] d;
   logic [W-1:0] qm;
   logic [W-1:0] qs;
   logic         tc;

   int errors = 0;
   int checks = 0;
   int mdl;

   typedef struct packed {
      logic [W-1:0] qs;
      logic         tc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   t_ms_counter #(.WIDTH(W)) dut (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .up   (up),
      .load (load),
      .d    (d),
      .qm   (qm),
      .qs   (qs),
      .tc   (tc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit tc_of(input int v, input bit u);
      return u ? (v == M - 1) : (v == 0);
   endfunction

   function automatic int next_val(input int v, input bit e, input bit u,
                                   input bit l, input int dv);
      if (l) return dv;
      if (!e) return v;
      if (SAT && tc_of(v, u)) return v;
      return u ? (v + 1) % M : (v + M - 1) % M;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
      end
   endtask

   // Called at negedge+2: apply inputs for the coming cycle, check tc
   // reacts combinationally, and queue the value expected after the edge.
   task automatic drive(input bit e, input bit u, input bit l,
                        input logic [W-1:0] dv);
      en = e;
      up = u;
      load = l;
      d = dv;
      #1;
      chk("tc_pre", 32'(tc), 32'(tc_of(mdl, u)));
      mdl = next_val(mdl, e, u, l, int'(dv));
      sb.push_back('{qs: W'(mdl), tc: tc_of(mdl, u)});
      @(negedge clk);
      #2;
   endtask

   // Monitor: qs/tc after each falling edge.
   initial forever begin
      @(negedge clk);
      #1;
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         chk("qs", 32'(qs), 32'(mon_e.qs));
         chk("tc", 32'(tc), 32'(mon_e.tc));
      end
   end

   // Monitor: master already holds the next count during the high phase.
   initial forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
         chk("qm_lead", 32'(qm), 32'(sb[0].qs));
      end
   end

   initial begin
      rst = 1'b1;
      en = 1'b0;
      up = 1'b1;
      load = 1'b0;
      d = '0;
      mdl = 0;
      #1;
      chk("rst_qs", 32'(qs), 32'd0);
      chk("rst_qm", 32'(qm), 32'd0);
      chk("rst_tc_up", 32'(tc), 32'd0);
      up = 1'b0;
      #1;
      chk("rst_tc_dn", 32'(tc), 32'd1);
      up = 1'b1;
      @(negedge clk);
      #2;
      rst = 1'b0;

      repeat (5) drive(1'b1, 1'b1, 1'b0, '0);
      drive(1'b1, 1'b1, 1'b0, '0);
      drive(1'b1, 1'b0, 1'b0, '0);

      drive(1'b0, 1'b1, 1'b1, 4'hE);
      drive(1'b1, 1'b1, 1'b0, '0);
      drive(1'b1, 1'b1, 1'b0, '0);

      drive(1'b0, 1'b1, 1'b1, 4'h0);
      drive(1'b1, 1'b0, 1'b0, '0);
      drive(1'b1, 1'b0, 1'b0, '0);

      drive(1'b0, 1'b1, 1'b1, 4'h7);
      repeat (3) drive(1'b0, 1'($urandom_range(0, 1)), 1'b0, 4'($urandom));
      drive(1'b1, 1'b1, 1'b1, 4'h3);

      drive(1'b0, 1'b1, 1'b1, 4'h9);
      en = 1'b1;
      up = 1'b1;
      load = 1'b0;
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_qm", 32'(qm), 32'd0);
      chk("mid_rst_qs", 32'(qs), 32'd0);
      chk("mid_rst_tc", 32'(tc), 32'd0);
      rst = 1'b0;
      mdl = next_val(0, 1'b1, 1'b1, 1'b0, 0);
      sb.push_back('{qs: W'(mdl), tc: tc_of(mdl, 1'b1)});
      #1;
      chk("rel_qm", 32'(qm), 32'd1);
      chk("rel_qs", 32'(qs), 32'd0);
      @(negedge clk);
      #2;

      en = 1'b0;
      load = 1'b1;
      d = 4'hA;
      #1;
      rst = 1'b1;
      #1;
      chk("ld_rst_qs", 32'(qs), 32'd0);
      chk("ld_rst_qm", 32'(qm), 32'd0);
      load = 1'b0;
      @(posedge clk);
      #2;
      rst = 1'b0;
      mdl = 0;
      sb.push_back('{qs: W'(0), tc: tc_of(0, up)});
      #1;
      chk("ld_rel_qm", 32'(qm), 32'd0);
      @(negedge clk);
      #2;

      for (int i = 0; i < 300; i++) begin
         drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
               $urandom_range(0, 7) == 0, 4'($urandom));
      end

      for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
      #3;
      chk("drain", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/t_ms_counter.md
T_MS_COUNTER -- requirements
Module: t_ms_counter

Interface
REQ-001 SHALL have parameter: WIDTH, 4, counter bit count (legal range 1..32).
REQ-002 SHALL have port: clk  input  1  single clock; master phase while clk=1, slave phase while clk=0.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: en  input  1  count enable.
REQ-005 SHALL have port: up  input  1  direction; 1 = increment, 0 = decrement.
REQ-006 SHALL have port: load  input  1  parallel load request.
REQ-007 SHALL have port: d  input  WIDTH  parallel load value.
REQ-008 SHALL have port: qm  output  WIDTH  master-stage state.
REQ-009 SHALL have port: qs  output  WIDTH  slave-stage state, the visible count.
REQ-010 SHALL have port: tc  output  1  terminal count flag.

Function
REQ-011 SHALL build each bit i as a master-slave T element: master transparent while clk=1, slave transparent while clk=0.
REQ-012 SHALL compute the next state of each master only from qs and the inputs, never from qm, so the loop cannot oscillate.
REQ-013 SHALL, while clk=1, drive qm[i] = qs[i] XOR t[i], and SHALL hold qs.
REQ-014 SHALL, while clk=0, drive qs = qm, and SHALL hold qm; a count step is visible on qs at the falling edge.
REQ-015 SHALL sample en, up, load and d at the value present at the falling edge of clk; inputs SHALL be stable through the clk=1 phase.
REQ-016 SHALL, for up=1, use toggle t[i] = en AND (qs[i-1:0] all ones), with t[0] = en.
REQ-017 SHALL, for up=0, use toggle t[i] = en AND (qs[i-1:0] all zeros), with t[0] = en.
REQ-018 SHALL, when load=1, set qm = d regardless of en and up; load SHALL take priority over count.
REQ-019 SHALL hold qm = qs when en=0 and load=0.
REQ-020 SHALL drive tc combinationally from qs and up: tc = 1 when up=1 and qs equals all ones, or when up=0 and qs equals all zeros.
REQ-021 SHALL wrap modulo 2^WIDTH: all ones +1 gives 0, and 0 -1 gives all ones (default build).
REQ-022 SHALL apply a direction change with en=1 on the same falling edge, with no idle cycle.

Reset
REQ-023 SHALL, while rst=1, force qm and qs to 0 immediately and independent of clk.
REQ-024 SHALL drive tc = NOT up during reset.
REQ-025 SHALL, on rst deassertion in mid-phase, leave qs at 0 until the next falling edge; the first count step SHALL occur no earlier than that edge.
REQ-026 SHALL, on rst assertion mid-count or mid-load, discard the pending update.

Configuration
REQ-027 SHALL, when macro T_MS_COUNTER_SAT_EN is defined, force all t[i] = 0 when tc=1 and en=1 and load=0, so the count saturates at the end value.
REQ-028 SHALL, without T_MS_COUNTER_SAT_EN, wrap per REQ-021.
REQ-029 SHALL let load override saturation in both builds.

Structure
REQ-030 SHALL place the direction constants DIR_DOWN=0 and DIR_UP=1 and the default width constant in shared package t_ms_pkg.
REQ-031 SHALL implement one-bit sub-module t_ms_stage (ports clk, rst, t, ld, ldv, qm, qs), instantiated WIDTH times by generate.
REQ-032 SHALL compute the toggle/carry chain and tc in the top level.

Verification
REQ-033 SHALL cover, WIDTH=4: rst=1 for 10 ns, then en=1, up=1 for 5 falling edges -> qs = 0,1,2,3,4,5; qm leads qs by half a cycle.
REQ-034 SHALL cover: load=1 with d=4'hE, then en=1, up=1 for 2 edges -> qs = E, F (tc=1), then 0 (tc=0); saturate build holds F.
REQ-035 SHALL cover: from qs=0 with up=0, en=1 -> tc=1 before the edge, then qs=F; saturate build holds 0 and tc stays 1.
REQ-036 SHALL cover: en=0 for 3 edges at qs=7 -> qs and qm stay 7; load=1 with d=3 and en=1 -> qs=3.
REQ-037 SHALL cover: rst asserted mid clk=1 phase at qs=9 -> qm=qs=0 at once; after release the first edge gives qs=1.
REQ-038 SHALL cover: up toggled 1->0 at qs=5 with en=1 -> qs=6, then 5.
